// File: rtl/uart_tx_frame_if.sv
// Host-side write port of the UART transmitter: write strobe, word and status.
// LEVEL_W must equal $clog2(FIFO_DEPTH)+1 of the attached transmitter.
interface uart_tx_frame_if #(
    parameter int DATA_BITS = 8,
    parameter int LEVEL_W   = 5
);
    logic                 tx_wr;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_full;
    logic                 tx_busy;
    logic                 tx_ovf;
    logic [LEVEL_W-1:0]   tx_level;

    modport master (
        output tx_wr,
        output tx_data,
        input  tx_full,
        input  tx_busy,
        input  tx_ovf,
        input  tx_level
    );

    modport slave (
        input  tx_wr,
        input  tx_data,
        output tx_full,
        output tx_busy,
        output tx_ovf,
        output tx_level
    );
endinterface

// File: rtl/uart_tx_frame.sv
// RS-232 transmitter: 5..8 data bits, optional parity, 1 or 2 stop bits.
// Define UART_TX_FIFO_EN to buffer writes in a FIFO_DEPTH-entry FIFO.
module uart_tx_frame #(
    parameter int CLK_FREQ   = 66666666,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic            clk,
    input  logic            reset,
    uart_tx_frame_if.slave  tx,
    output logic            TxD
);
    localparam int DIV     = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int CNT_W   = (DIV < 2) ? 1 : $clog2(DIV);
    localparam int IDX_W   = $clog2(DATA_BITS);
    localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

    if (DIV < 2) begin : g_div_chk
        $error("uart_tx_frame: bit period below 2 clocks");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 txd_q, txd_d;
    logic                 ovf_q, ovf_d;

    logic                 tick;
    logic                 avail;
    logic                 load;
    logic                 full;
    logic [DATA_BITS-1:0] word;

    function automatic logic txd_of(state_t s, logic b0, logic p);
        case (s)
            START:   return 1'b0;
            DATA:    return b0;
            PAR:     return p;
            default: return 1'b1;
        endcase
    endfunction

`ifdef UART_TX_FIFO_EN
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LEVEL_W-1:0]   level_q, level_d;
    logic                 push;

    assign full  = (level_q == LEVEL_W'(FIFO_DEPTH));
    assign push  = tx.tx_wr & ~full;
    assign avail = (level_q != '0);
    assign word  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (load) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, load})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= tx.tx_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign tx.tx_level = level_q;
    assign tx.tx_busy  = (state_q != IDLE) | avail;
    // Line value follows the next state so START and TxD change together.
    assign txd_d = txd_of(state_d, shift_d[0], par_d);
`else
    assign full  = (state_q != IDLE);
    assign avail = tx.tx_wr & ~full;
    assign word  = tx.tx_data;

    assign tx.tx_level = {LEVEL_W{1'b0}};
    assign tx.tx_busy  = (state_q != IDLE);
    // Word is loaded on the accepting edge; the line follows one cycle later.
    assign txd_d = txd_of(state_q, shift_q[0], par_q);
`endif

    assign tick       = (cnt_q == '0);
    assign ovf_d      = tx.tx_wr & full;
    assign tx.tx_full = full;
    assign tx.tx_ovf  = ovf_q;
    assign TxD        = txd_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        load    = 1'b0;

        if (state_q != IDLE) cnt_d = tick ? CNT_MAX : cnt_q - 1'b1;

        unique case (state_q)
            IDLE: begin
                if (avail) begin
                    load    = 1'b1;
                    state_d = START;
                    cnt_d   = CNT_MAX;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
                    if (idx_q == LAST_DATA) begin
                        idx_d   = '0;
                        state_d = (PARITY != 0) ? PAR : STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            PAR: begin
                if (tick) begin
                    state_d = STOP;
                    idx_d   = '0;
                end
            end
            STOP: begin
                if (tick) begin
                    if (idx_q != LAST_STOP) begin
                        idx_d = idx_q + 1'b1;
                    end else if (avail) begin
                        load    = 1'b1;
                        state_d = START;
                        idx_d   = '0;
                    end else begin
                        state_d = IDLE;
                        idx_d   = '0;
                        cnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase

        if (load) begin
            shift_d = word;
            par_d   = (PARITY == 1) ? ~^word : ^word;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            txd_q   <= txd_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised RS-232 transmitter: serialises words of configurable width with optional parity and one or two stop bits, using an exact integer bit-period divider. An optional transmit FIFO allows back-to-back frames with no idle gap. Sits between the host-side command/telemetry logic and the board TxD pin and replaces the fixed 8N2 transmitter.

## Interface
- CLK_FREQ, 66666666: system clock frequency in Hz.
- BAUD, 115200: line rate in bit/s.
- DATA_BITS, 8: data bits per frame, legal 5..8.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 16: FIFO entries, power of 2, ≥ 2; used only when the FIFO is compiled in.
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- tx_wr  in  1  write strobe; the word is accepted on a rising edge where tx_wr=1 and tx_full=0.
- tx_data  in  DATA_BITS  word to send, LSB first.
- tx_full  out  1  no space; writes are dropped.
- tx_busy  out  1  frame in progress or data pending.
- tx_ovf  out  1  one-cycle pulse when tx_wr=1 while tx_full=1.
- tx_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy; constant 0 without the FIFO.
- TxD  out  1  registered serial output; idle high.

## Operation
- DIV = (CLK_FREQ + BAUD/2) / BAUD, integer. Every bit lasts exactly DIV cycles. Elaboration error if DIV < 2.
- Bit counter: $clog2(DIV) bits. It reloads at every bit boundary. There is no fractional accumulator, so there is no period jitter.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE → START when data is available: the FIFO is not empty, or a write is accepted in the no-FIFO build.
  - START → DATA after DIV cycles.
  - DATA runs DATA_BITS bit periods, LSB first, using a bit index 0..DATA_BITS-1.
  - After DATA, go to PAR if PARITY≠0, else to STOP.
  - PAR → STOP after DIV cycles.
  - STOP runs STOP_BITS periods. At the end it goes to START if data is available (back-to-back), else to IDLE.
- TxD values: START = 0; DATA = shift-register LSB; PAR: even = ^word, odd = ~^word; STOP and IDLE = 1.
- Word load: the word is popped into the shift register on the same edge that enters START. Parity is computed from the loaded word.
- With the FIFO:
  - tx_full = (level == FIFO_DEPTH).
  - A write while full is dropped and raises tx_ovf, even if a pop occurs on the same edge.
  - A simultaneous push and pop while not full leaves the level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- tx_busy = (state ≠ IDLE) | (level ≠ 0).
- Reset values, asserted at any time including mid-frame: state=IDLE, TxD=1, FIFO empty, level=0, tx_full=0 (1 without the FIFO only when not IDLE), tx_busy=0, tx_ovf=0, counters=0. A partial frame is abandoned and the line returns high immediately.

## Timing
- Write accepted at edge E while IDLE with an empty FIFO:
  - FIFO build: the word enters the FIFO at E, START is entered at E+1, and TxD falls at E+1.
  - No-FIFO build: START is entered at E, and TxD falls at E+1 (one output register stage).
- Frame length = (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × DIV cycles.
- Back-to-back frames: the next START bit immediately follows the last stop period, with zero idle cycles.
- tx_full and tx_level update on the edge following the accepting write or pop.
- tx_ovf is high for exactly the cycle after the dropped write.

## Configuration
- UART_TX_FIFO_EN defined: a FIFO_DEPTH-entry FIFO buffers writes. tx_full reflects FIFO occupancy.
- UART_TX_FIFO_EN undefined: no buffering.
  - A write is accepted only in IDLE.
  - tx_full = (state ≠ IDLE); tx_level = 0.
  - The word loads directly into the shift register on the accepting edge.

## Test plan
- CLK_FREQ=1000000, BAUD=100000 (DIV=10), 8N1; write 0x55 → TxD sequence 0,1,0,1,0,1,0,1,0,1, each bit held 10 cycles; frame 100 cycles; tx_busy drops after that.
- Same clocking, PARITY=2, STOP_BITS=2, DATA_BITS=7; write 0x03 → start 0, data 1,1,0,0,0,0,0, parity 0, stop 1,1; frame 110 cycles. With PARITY=1 → parity bit 1.
- FIFO build, depth 4; write 0xA0,0xA1,0xA2,0xA3,0xA4 on consecutive cycles → tx_full asserts after the fifth accepted write; 0xA4 accepted only if a pop has occurred; no gap between frames (stop-bit end to next start = 0 cycles).
- Write while tx_full=1 → tx_ovf pulses one cycle, tx_level unchanged, the word is never transmitted.
- Assert reset 37 cycles into a frame → TxD=1, tx_busy=0, tx_level=0 within the reset assertion; the next write after release produces a clean full frame.
- No-FIFO build; write during DATA → dropped with tx_ovf; a write on the first IDLE cycle starts a frame with TxD falling one cycle later.
